// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller for a pipelined CPU: divides clk into tick
// opportunities, issues cpu_tick pulses while running, and stops on user
// HALT, step completion, breakpoints, EBREAK or a CPU error.
module cpu_run_ctrl #(
  parameter int CLK_DIV = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  cmd_sel,
  input  logic [31:0] id_pc,
  input  logic        id_valid,
  input  logic        ebreak,
  input  logic [3:0]  error,
  output logic        cpu_tick,
  output logic        running,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [3:0]  fault_code,
  output logic [15:0] steps_left,
  output logic [31:0] tick_cnt
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_FAULT} state_t;
  typedef enum logic [1:0] {OP_HALT, OP_RUN, OP_STEP, OP_SETBP} op_t;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_USER  = 3'd1;
  localparam logic [2:0] CAUSE_STEP  = 3'd2;
  localparam logic [2:0] CAUSE_BP0   = 3'd3;
  localparam logic [2:0] CAUSE_BP1   = 3'd4;
  localparam logic [2:0] CAUSE_EBRK  = 3'd5;
  localparam logic [2:0] CAUSE_ERROR = 3'd6;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic             opp;
  logic             skip_bp, skip_d;
  logic [1:0][31:0] bp_addr;
  logic [1:0]       bp_en;
  logic [1:0]       bp_hit;
  logic             active, stop;
  logic [2:0]       stop_cause;
  logic [2:0]       cause_d;
  logic [3:0]       fault_d;
  logic [15:0]      steps_d;
  op_t              op;
  logic             cmd_halt, cmd_run, cmd_step, cmd_setbp;

  assign cmd_ready = 1'b1;
  assign op        = op_t'(cmd_op);
  assign cmd_halt  = cmd_valid && (op == OP_HALT);
  assign cmd_run   = cmd_valid && (op == OP_RUN);
  assign cmd_step  = cmd_valid && (op == OP_STEP);
  assign cmd_setbp = cmd_valid && (op == OP_SETBP);

  assign active  = (state == S_RUN) || (state == S_STEP);
  assign running = active;
  assign halted  = (state == S_HALT) || (state == S_FAULT);
  assign opp     = (div_cnt == DIV_LAST);

  // skip_bp lets the first tick after a resume leave a breakpoint PC.
  assign bp_hit[0] = id_valid && bp_en[0] && (id_pc == bp_addr[0]) && !skip_bp;
  assign bp_hit[1] = id_valid && bp_en[1] && (id_pc == bp_addr[1]) && !skip_bp;

  // Stop condition with priority error > ebreak > bp0 > bp1.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    stop       = 1'b0;
    stop_cause = CAUSE_NONE;
    if (active) begin
      if (error != 4'd0) begin
        stop = 1'b1; stop_cause = CAUSE_ERROR;
      end else if (ebreak) begin
        stop = 1'b1; stop_cause = CAUSE_EBRK;
      end else if (bp_hit[0]) begin
        stop = 1'b1; stop_cause = CAUSE_BP0;
      end else if (bp_hit[1]) begin
        stop = 1'b1; stop_cause = CAUSE_BP1;
      end
    end
  end

  // A HALT command or a stop condition suppresses the tick in its own clk.
  assign cpu_tick = opp && active && !stop && !cmd_halt;

  // Next-state and next status-register values.
  always_comb begin
    state_d = state;
    cause_d = halt_cause;
    fault_d = fault_code;
    steps_d = steps_left;
    skip_d  = skip_bp;
    case (state)
      S_HALT: begin
        if (cmd_run) begin
          state_d = S_RUN;
          cause_d = CAUSE_NONE;
          skip_d  = 1'b1;
        end else if (cmd_step) begin
          state_d = S_STEP;
          cause_d = CAUSE_NONE;
          skip_d  = 1'b1;
          steps_d = (cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd_arg[15:0];
        end
      end
      S_RUN, S_STEP: begin
        if (cmd_halt) begin
          state_d = S_HALT;
          cause_d = CAUSE_USER;
        end else if (stop) begin
          state_d = (stop_cause == CAUSE_ERROR) ? S_FAULT : S_HALT;
          cause_d = stop_cause;
          if (stop_cause == CAUSE_ERROR) fault_d = error;
        end else if (cpu_tick) begin
          skip_d = 1'b0;
          if (state == S_STEP) begin
            steps_d = steps_left - 16'd1;
            if (steps_left <= 16'd1) begin
              state_d = S_HALT;
              cause_d = CAUSE_STEP;
            end
          end
        end
      end
      S_FAULT: begin
        if (cmd_halt) begin
          state_d = S_HALT;
          fault_d = 4'd0;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_HALT;
    else     state <= state_d;
  end

  // Status registers that follow the state machine decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_cause <= CAUSE_NONE;
      fault_code <= 4'd0;
      steps_left <= 16'd0;
      skip_bp    <= 1'b0;
    end else begin
      halt_cause <= cause_d;
      fault_code <= fault_d;
      steps_left <= steps_d;
      skip_bp    <= skip_d;
    end
  end

  // Free-running tick divider and issued-tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= 32'd0;
    end else begin
      div_cnt <= opp ? '0 : div_cnt + DIV_W'(1);
      if (cpu_tick) tick_cnt <= tick_cnt + 32'd1;
    end
  end

  // Breakpoint registers, writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_addr <= '0;
      bp_en   <= '0;
    end else if (cmd_setbp) begin
      bp_addr[cmd_sel[0]] <= cmd_arg;
      bp_en[cmd_sel[0]]   <= cmd_sel[1];
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: the stimulus process pushes expected
// ticks and status snapshots; the monitor pops and compares them.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [1:0]  cmd_sel = 2'd0;
  logic [31:0] id_pc = 32'h100;
  logic        id_valid = 1'b1;
  logic        ebreak = 1'b0;
  logic [3:0]  error = 4'd0;
  logic        cpu_tick, running, halted;
  logic [2:0]  halt_cause;
  logic [3:0]  fault_code;
  logic [15:0] steps_left;
  logic [31:0] tick_cnt;

  localparam logic [1:0] HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, SETBP = 2'd3;

  typedef struct packed {
    logic        running;
    logic        halted;
    logic [2:0]  cause;
    logic [3:0]  fault;
    logic [15:0] steps;
    logic [31:0] tick;
  } stat_t;

  cpu_run_ctrl #(.CLK_DIV(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_sel(cmd_sel), .id_pc(id_pc),
    .id_valid(id_valid), .ebreak(ebreak), .error(error), .cpu_tick(cpu_tick),
    .running(running), .halted(halted), .halt_cause(halt_cause),
    .fault_code(fault_code), .steps_left(steps_left), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // Expectation FIFOs: written only by stimulus (wr), drained only by monitor (rd).
  logic [31:0] tick_exp [64];
  int          tick_gap [64];
  stat_t       stat_exp [64];
  string       stat_name [64];
  int tick_wr = 0, tick_rd = 0, stat_wr = 0, stat_rd = 0;
  int n_checks = 0, n_pass = 0;
  logic done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every tick and every requested snapshot at negedge.
  initial begin
    int neg_cnt = 0;
    int last_tick = 0;
    stat_t act;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (cpu_tick) begin
        check("tick_expected", 64'(tick_rd < tick_wr), 64'd1);
        if (tick_rd < tick_wr) begin
          check("tick_cnt_at_tick", 64'(tick_cnt), 64'(tick_exp[tick_rd]));
          if (tick_gap[tick_rd] != 0)
            check("tick_gap", 64'(neg_cnt - last_tick), 64'(tick_gap[tick_rd]));
          tick_rd++;
        end
        last_tick = neg_cnt;
      end
      if (stat_rd < stat_wr) begin
        act = '{running, halted, halt_cause, fault_code, steps_left, tick_cnt};
        check(stat_name[stat_rd], 64'(act), 64'(stat_exp[stat_rd]));
        stat_rd++;
      end
      if (done && stat_rd == stat_wr) begin
        check("ticks_outstanding", 64'(tick_wr - tick_rd), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg, input logic [1:0] sel);
    next_cyc();
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_sel = sel;
    next_cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic push_tick(input logic [31:0] cnt, input int gap);
    tick_exp[tick_wr] = cnt;
    tick_gap[tick_wr] = gap;
    tick_wr++;
  endtask

  task automatic push_stat(input string name, input logic run, input logic hlt,
                           input logic [2:0] cause, input logic [3:0] fault,
                           input logic [15:0] steps, input logic [31:0] tick);
    stat_exp[stat_wr]  = '{run, hlt, cause, fault, steps, tick};
    stat_name[stat_wr] = name;
    stat_wr++;
  endtask

  // Pacing waits are bounded; a timeout shows up as a failed snapshot.
  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 200) begin next_cyc(); n++; end
  endtask

  task automatic wait_tick_cnt(input logic [31:0] v);
    int n = 0;
    while (tick_cnt != v && n < 200) begin next_cyc(); n++; end
  endtask

  initial begin
    push_stat("reset_state", 0, 1, 0, 0, 0, 0);
    repeat (3) next_cyc();
    rst = 1'b0;

    // STEP 3: three ticks five clks apart, then step-done halt.
    push_tick(0, 0); push_tick(1, 5); push_tick(2, 5);
    send(STEP, 32'd3, 2'b00);
    wait_halted();
    push_stat("step3_done", 0, 1, 2, 0, 0, 3);
    repeat (8) next_cyc();

    // bp0 at 0x10: run, then hit it.
    send(SETBP, 32'h10, 2'b10);
    push_tick(3, 0); push_tick(4, 5);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(5);
    id_pc = 32'h10;
    wait_halted();
    push_stat("bp0_hit", 0, 1, 3, 0, 0, 5);
    repeat (6) next_cyc();

    // Resume from the breakpoint PC: one tick escapes, then normal running.
    push_tick(5, 0);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(6);
    id_pc = 32'h14;
    push_tick(6, 5); push_tick(7, 5);
    wait_tick_cnt(8);
    push_stat("resumed_running", 1, 0, 0, 0, 0, 8);

    // HALT command and bp match in the same clk: user cause wins.
    next_cyc();
    id_pc = 32'h10;
    cmd_valid = 1'b1; cmd_op = HALT; cmd_arg = 32'd0; cmd_sel = 2'b00;
    next_cyc();
    cmd_valid = 1'b0;
    push_stat("halt_vs_bp", 0, 1, 1, 0, 0, 8);
    repeat (6) next_cyc();

    // error with ebreak: FAULT wins, RUN ignored, HALT clears the code.
    send(SETBP, 32'd0, 2'b00);
    id_pc = 32'h20;
    push_tick(8, 0);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(9);
    error = 4'd1; ebreak = 1'b1;
    wait_halted();
    push_stat("fault_entry", 0, 1, 6, 1, 0, 9);
    error = 4'd0; ebreak = 1'b0;
    send(RUN, 32'd0, 2'b00);
    repeat (10) next_cyc();
    push_stat("fault_run_ignored", 0, 1, 6, 1, 0, 9);
    send(HALT, 32'd0, 2'b00);
    push_stat("fault_cleared", 0, 1, 6, 0, 0, 9);

    // EBREAK alone.
    push_tick(9, 0);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(10);
    ebreak = 1'b1;
    wait_halted();
    push_stat("ebreak_halt", 0, 1, 5, 0, 0, 10);
    ebreak = 1'b0;

    // bp1 at 0x40.
    send(SETBP, 32'h40, 2'b11);
    push_tick(10, 0);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(11);
    id_pc = 32'h40;
    wait_halted();
    push_stat("bp1_hit", 0, 1, 4, 0, 0, 11);

    // STEP 0 loads 1: exactly one tick (leaves the bp1 PC).
    push_tick(11, 0);
    send(STEP, 32'd0, 2'b00);
    wait_halted();
    push_stat("step0_done", 0, 1, 2, 0, 0, 12);
    repeat (8) next_cyc();

    // error is not tracked while halted.
    error = 4'd3;
    repeat (6) next_cyc();
    push_stat("error_in_halt", 0, 1, 2, 0, 0, 12);
    next_cyc();
    error = 4'd0;

    // tick_cnt wrap.
    force dut.tick_cnt = 32'hFFFF_FFFF;
    #1 release dut.tick_cnt;
    push_stat("tick_cnt_preload", 0, 1, 2, 0, 0, 32'hFFFF_FFFF);
    push_tick(32'hFFFF_FFFF, 0);
    send(STEP, 32'd1, 2'b00);
    wait_halted();
    push_stat("tick_cnt_wrap", 0, 1, 2, 0, 0, 0);

    // Reset mid-RUN while cpu_tick is high.
    id_pc = 32'h100;
    push_tick(0, 0);
    send(RUN, 32'd0, 2'b00);
    wait_tick_cnt(1);
    begin
      int n = 0;
      while (!cpu_tick && n < 50) begin next_cyc(); n++; end
    end
    #1 rst = 1'b1;
    push_stat("async_reset", 0, 1, 0, 0, 0, 0);
    repeat (3) next_cyc();
    rst = 1'b0;
    repeat (20) next_cyc();
    push_stat("post_reset_idle", 0, 1, 0, 0, 0, 0);
    next_cyc();
    done = 1'b1;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5, meaning clk cycles per CPU tick opportunity; legal values are >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single 100 MHz clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: the command strobe.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the command accept signal.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 HALT, 01 RUN, 10 STEP, 11 SETBP.
REQ-007 SHALL have port cmd_arg, input, 32 bits: the step count in [15:0], or the breakpoint address.
REQ-008 SHALL have port cmd_sel, input, 2 bits: [0] selects bp0/bp1; [1] is the breakpoint enable for SETBP.
REQ-009 SHALL have port id_pc, input, 32 bits: the PC of the instruction in the ID stage.
REQ-010 SHALL have port id_valid, input, 1 bit: id_pc holds a real (non-bubble) instruction.
REQ-011 SHALL have port ebreak, input, 1 bit: EBREAK decoded in ID.
REQ-012 SHALL have port error, input, 4 bits: CPU error code, where 0 means none.
REQ-013 SHALL have port cpu_tick, output, 1 bit: a one-clk pulse that advances the pipeline one CPU cycle.
REQ-014 SHALL have port running, output, 1 bit: state is RUN or STEP.
REQ-015 SHALL have port halted, output, 1 bit: state is HALT or FAULT.
REQ-016 SHALL have port halt_cause, output, 3 bits: 0 none, 1 user, 2 step done, 3 bp0, 4 bp1, 5 ebreak, 6 error.
REQ-017 SHALL have port fault_code, output, 4 bits: the latched error code.
REQ-018 SHALL have port steps_left, output, 16 bits: remaining step ticks.
REQ-019 SHALL have port tick_cnt, output, 32 bits: the number of issued cpu_tick pulses.

Function
REQ-020 SHALL implement states HALT, RUN, STEP and FAULT, held in a clk-domain register.
REQ-021 SHALL run a free-running divider div_cnt that counts 0..CLK_DIV-1 and wraps; a tick opportunity (opp) occurs when div_cnt==CLK_DIV-1.
REQ-022 SHALL hold cmd_ready at 1 in every state; a command is accepted on any clk with cmd_valid=1.
REQ-023 SHALL, on SETBP, load the selected bp address and enable bit from cmd_arg and cmd_sel[1] on that clk edge, in any state, with no state change.
REQ-024 SHALL, on HALT in RUN or STEP, go to HALT with cause=1; on HALT in FAULT, go to HALT, keep halt_cause, and clear fault_code to 0.
REQ-025 SHALL, on RUN in HALT, go to RUN, set skip_bp=1 and clear halt_cause to 0.
REQ-026 SHALL, on STEP in HALT, go to STEP, load steps_left=cmd_arg[15:0] (a value of 0 loads 1), set skip_bp=1 and clear halt_cause to 0.
REQ-027 SHALL ignore RUN and STEP commands in RUN, STEP and FAULT.
REQ-028 SHALL compute a stop condition combinationally every clk in RUN or STEP, with priority error!=0 > ebreak > bp0 match > bp1 match.
REQ-029 SHALL define a breakpoint match as: id_valid=1, bp enabled, id_pc==bp address, and skip_bp=0.
REQ-030 SHALL, on error!=0 in RUN or STEP, go to FAULT, set cause=6, latch fault_code=error and issue no tick that clk.
REQ-031 SHALL, on ebreak or a bp match in RUN or STEP, go to HALT with cause 5, 3 or 4 and issue no tick that clk.
REQ-032 SHALL assert cpu_tick = opp and state in {RUN, STEP} and no stop condition and no HALT command that clk.
REQ-033 SHALL increment tick_cnt by 1 per cpu_tick, wrapping from 0xFFFFFFFF to 0.
REQ-034 SHALL clear skip_bp on the first issued cpu_tick after entering RUN or STEP, so a resume from a breakpoint PC proceeds.
REQ-035 SHALL, in STEP, decrement steps_left on each cpu_tick; the tick that takes it from 1 to 0 moves the state to HALT with cause=2 on the same edge.
REQ-036 SHALL give a HALT command precedence over a stop condition in the same clk (cause=1).
REQ-037 SHALL give a stop condition precedence over step completion (no tick is issued, so steps_left does not change).
REQ-038 SHALL not track error while in HALT; FAULT is entered only from RUN or STEP.
REQ-039 SHALL have running and halted decode from the registered state (zero latency).

Reset
REQ-040 SHALL, while rst=1, asynchronously set: state=HALT, div_cnt=0, cpu_tick=0, running=0, halted=1, halt_cause=0, fault_code=0, steps_left=0, tick_cnt=0, skip_bp=0, both bp enables=0, both bp addresses=0.
REQ-041 SHALL, when rst asserts mid-RUN, drop cpu_tick in the same clk and issue no tick until a new RUN or STEP command after release.

Verification
REQ-042 SHALL pass: STEP with arg 3, CLK_DIV=5 -> exactly 3 cpu_tick pulses 5 clks apart, then halted=1, cause=2, steps_left=0, tick_cnt=3.
REQ-043 SHALL pass: SETBP bp0=0x0000_0010 enabled, then RUN, and id_pc=0x10 with id_valid=1 -> no further tick, cause=3; a second RUN with id_pc still 0x10 -> 1 tick issued, then normal running.
REQ-044 SHALL pass: in RUN, error=1 together with ebreak=1 -> FAULT, cause=6, fault_code=1; a RUN command is then ignored; a HALT command -> HALT with fault_code=0.
REQ-045 SHALL pass: HALT command and a bp match in the same clk -> cause=1, no tick.
REQ-046 SHALL pass: STEP with arg 0 -> exactly 1 tick, then cause=2.
REQ-047 SHALL pass: preload tick_cnt to 0xFFFFFFFF via 2^32-1 ticks or a force, then 1 tick -> tick_cnt=0; assert rst mid-RUN -> all outputs at reset values asynchronously.
